// File: rtl/jk_reg_bank.sv
// WIDTH-bit register bank with per-bit JK control, up/down counting,
// parallel load, a one-cycle change strobe and a sticky wrap flag.
module jk_reg_bank #(
    parameter int unsigned          WIDTH     = 4,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             R,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             tc,
    output logic             chg,
    output logic             ovf
);

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    mode_t            op;
    logic [WIDTH-1:0] next_q;
    logic             wrap;

    assign op   = mode_t'(mode);
    assign Qbar = ~Q;

    // A counter wraps exactly when it sits at its terminal value.
    assign tc   = ((op == MODE_UP) && (&Q)) || ((op == MODE_DOWN) && (~|Q));
    assign wrap = en && tc;

    always_comb begin
        logic [WIDTH-1:0] up_t;
        logic [WIDTH-1:0] dn_t;
        up_t    = '0;
        dn_t    = '0;
        up_t[0] = 1'b1;
        dn_t[0] = 1'b1;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            up_t[i] = up_t[i-1] & Q[i-1];
            dn_t[i] = dn_t[i-1] & ~Q[i-1];
        end
        next_q = Q;
        case (op)
            MODE_JK:   next_q = (J & ~Q) | (~K & Q);
            MODE_UP:   next_q = Q ^ up_t;
            MODE_DOWN: next_q = Q ^ dn_t;
            MODE_LOAD: next_q = J;
            default:   next_q = Q;
        endcase
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            Q   <= RESET_VAL;
            chg <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if (en) begin
                Q <= next_q;
            end
            chg <= en && (next_q != Q);
            if (wrap) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed-vector bench for jk_reg_bank (WIDTH=4, RESET_VAL=0).
module tb_jk_reg_bank;

    logic       clk;
    logic       R;
    logic       en;
    logic [1:0] mode;
    logic [3:0] J;
    logic [3:0] K;
    logic       clr_ovf;
    logic [3:0] Q;
    logic [3:0] Qbar;
    logic       tc;
    logic       chg;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    jk_reg_bank #(.WIDTH(4), .RESET_VAL(4'b0000)) dut (
        .clk(clk), .R(R), .en(en), .mode(mode), .J(J), .K(K),
        .clr_ovf(clr_ovf), .Q(Q), .Qbar(Qbar), .tc(tc), .chg(chg), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        R = 1'b1; en = 1'b0; mode = 2'b00; J = '0; K = '0; clr_ovf = 1'b0;
        #50;
        checks++; if (Q !== 4'b0000) begin errors++; $display("FAIL reset_hold_q got %b exp %b", Q, 4'b0000); end
        #50;
        R = 1'b0;
        #1;
        checks++; if (Q !== 4'b0000) begin errors++; $display("FAIL reset_q got %b exp %b", Q, 4'b0000); end
        checks++; if (Qbar !== 4'b1111) begin errors++; $display("FAIL reset_qbar got %b exp %b", Qbar, 4'b1111); end
        checks++; if (chg !== 1'b0) begin errors++; $display("FAIL reset_chg got %b exp 0", chg); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc got %b exp 0", tc); end
    endtask

    task automatic test_jk();
        en = 1'b1; mode = 2'b00;
        J = 4'b0011; K = 4'b0000; tick();
        checks++; if (Q !== 4'b0011) begin errors++; $display("FAIL jk_set got %b exp %b", Q, 4'b0011); end
        checks++; if (chg !== 1'b1) begin errors++; $display("FAIL jk_set_chg got %b exp 1", chg); end
        J = 4'b0101; K = 4'b0101; tick();
        checks++; if (Q !== 4'b0110) begin errors++; $display("FAIL jk_toggle got %b exp %b", Q, 4'b0110); end
        checks++; if (Qbar !== 4'b1001) begin errors++; $display("FAIL jk_toggle_qbar got %b exp %b", Qbar, 4'b1001); end
        checks++; if (chg !== 1'b1) begin errors++; $display("FAIL jk_toggle_chg got %b exp 1", chg); end
        J = 4'b0000; K = 4'b0000; tick();
        checks++; if (Q !== 4'b0110) begin errors++; $display("FAIL jk_hold got %b exp %b", Q, 4'b0110); end
        checks++; if (chg !== 1'b0) begin errors++; $display("FAIL jk_hold_chg got %b exp 0", chg); end
        J = 4'b0000; K = 4'b0010; tick();
        checks++; if (Q !== 4'b0100) begin errors++; $display("FAIL jk_reset got %b exp %b", Q, 4'b0100); end
        checks++; if (chg !== 1'b1) begin errors++; $display("FAIL jk_reset_chg got %b exp 1", chg); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL jk_ovf got %b exp 0", ovf); end
    endtask

    task automatic test_count_up();
        mode = 2'b11; J = 4'b1110; K = 4'b1111; tick();
        checks++; if (Q !== 4'b1110) begin errors++; $display("FAIL up_load got %b exp %b", Q, 4'b1110); end
        mode = 2'b01; J = 4'b0101; K = 4'b1010; #1;
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL up_tc_before got %b exp 0", tc); end
        tick();
        checks++; if (Q !== 4'b1111) begin errors++; $display("FAIL up_to_max got %b exp %b", Q, 4'b1111); end
        checks++; if (tc !== 1'b1) begin errors++; $display("FAIL up_tc_max got %b exp 1", tc); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL up_ovf_pre got %b exp 0", ovf); end
        tick();
        checks++; if (Q !== 4'b0000) begin errors++; $display("FAIL up_wrap got %b exp %b", Q, 4'b0000); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL up_wrap_ovf got %b exp 1", ovf); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL up_tc_after_wrap got %b exp 0", tc); end
        tick();
        checks++; if (Q !== 4'b0001) begin errors++; $display("FAIL up_after_wrap got %b exp %b", Q, 4'b0001); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL up_ovf_sticky1 got %b exp 1", ovf); end
        tick();
        checks++; if (Q !== 4'b0010) begin errors++; $display("FAIL up_count2 got %b exp %b", Q, 4'b0010); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL up_ovf_sticky2 got %b exp 1", ovf); end
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        checks++; if (Q !== 4'b0011) begin errors++; $display("FAIL up_count3 got %b exp %b", Q, 4'b0011); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL up_ovf_clear got %b exp 0", ovf); end
    endtask

    task automatic test_count_down();
        mode = 2'b11; J = 4'b0001; K = 4'b1111; tick();
        checks++; if (Q !== 4'b0001) begin errors++; $display("FAIL dn_load got %b exp %b", Q, 4'b0001); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL dn_load_ovf got %b exp 0", ovf); end
        mode = 2'b10; J = 4'b1111; K = 4'b1111; #1;
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL dn_tc_one got %b exp 0", tc); end
        tick();
        checks++; if (Q !== 4'b0000) begin errors++; $display("FAIL dn_to_zero got %b exp %b", Q, 4'b0000); end
        checks++; if (tc !== 1'b1) begin errors++; $display("FAIL dn_tc_zero got %b exp 1", tc); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL dn_ovf_pre got %b exp 0", ovf); end
        tick();
        checks++; if (Q !== 4'b1111) begin errors++; $display("FAIL dn_wrap got %b exp %b", Q, 4'b1111); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL dn_tc_wrap got %b exp 0", tc); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL dn_wrap_ovf got %b exp 1", ovf); end
        tick();
        checks++; if (Q !== 4'b1110) begin errors++; $display("FAIL dn_after_wrap got %b exp %b", Q, 4'b1110); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL dn_tc_e got %b exp 0", tc); end
    endtask

    task automatic test_wrap_clr_hold();
        // clear ovf on a disabled edge: state holds, chg drops
        en = 1'b0; clr_ovf = 1'b1; tick();
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL hold_clr_ovf got %b exp 0", ovf); end
        checks++; if (Q !== 4'b1110) begin errors++; $display("FAIL hold_clr_q got %b exp %b", Q, 4'b1110); end
        checks++; if (chg !== 1'b0) begin errors++; $display("FAIL hold_clr_chg got %b exp 0", chg); end
        en = 1'b1; clr_ovf = 1'b0; mode = 2'b11; J = 4'b1111; tick();
        mode = 2'b01; clr_ovf = 1'b1; tick();
        checks++; if (Q !== 4'b0000) begin errors++; $display("FAIL setwins_q got %b exp %b", Q, 4'b0000); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL setwins_ovf got %b exp 1", ovf); end
        en = 1'b0; clr_ovf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (Q !== 4'b0000) begin errors++; $display("FAIL en0_q[%0d] got %b exp %b", i, Q, 4'b0000); end
            checks++; if (chg !== 1'b0) begin errors++; $display("FAIL en0_chg[%0d] got %b exp 0", i, chg); end
        end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL en0_ovf got %b exp 1", ovf); end
        mode = 2'b10; #1;
        checks++; if (tc !== 1'b1) begin errors++; $display("FAIL en0_tc_down got %b exp 1", tc); end
        mode = 2'b00; #1;
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL tc_jk got %b exp 0", tc); end
    endtask

    task automatic test_mid_reset();
        en = 1'b1; mode = 2'b11; J = 4'b0000; clr_ovf = 1'b1; tick();
        clr_ovf = 1'b0; mode = 2'b01;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL mr_pre_ovf got %b exp 0", ovf); end
        for (int i = 0; i < 5; i++) tick();
        checks++; if (Q !== 4'b0101) begin errors++; $display("FAIL mr_count got %b exp %b", Q, 4'b0101); end
        #2; R = 1'b1; #1;
        checks++; if (Q !== 4'b0000) begin errors++; $display("FAIL mr_async_q got %b exp %b", Q, 4'b0000); end
        checks++; if (Qbar !== 4'b1111) begin errors++; $display("FAIL mr_async_qbar got %b exp %b", Qbar, 4'b1111); end
        checks++; if (chg !== 1'b0) begin errors++; $display("FAIL mr_async_chg got %b exp 0", chg); end
        #3; R = 1'b0;
        tick();
        checks++; if (Q !== 4'b0001) begin errors++; $display("FAIL mr_resume got %b exp %b", Q, 4'b0001); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL mr_ovf got %b exp 0", ovf); end
        checks++; if (chg !== 1'b1) begin errors++; $display("FAIL mr_chg got %b exp 1", chg); end
    endtask

    initial begin
        test_reset();
        test_jk();
        test_count_up();
        test_count_down();
        test_wrap_clr_hold();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_reg_bank.md
# jk_reg_bank

Parametrised WIDTH-bit register bank built on JK flip-flop semantics. It is the multi-bit successor to the single JK flip-flop. Each bit obeys hold/set/reset/toggle from its own J/K pair, and the bank adds synchronous up/down counting, parallel load, a change strobe and a sticky overflow flag. It sits wherever the lab datapath needs a small control register or event counter with JK-style bit control.

## Interface
- WIDTH, 4, number of bits (≥2)
- RESET_VAL, 0, value loaded into Q on reset (WIDTH bits)

- clk  input  1  clock; all state updates on rising edge
- R  input  1  reset, asynchronous, active-high
- en  input  1  update enable; 0 = hold everything
- mode  input  2  00 JK, 01 count up, 10 count down, 11 load
- J  input  WIDTH  per-bit J (JK mode); load data (load mode)
- K  input  WIDTH  per-bit K (JK mode only)
- clr_ovf  input  1  synchronous clear of ovf
- Q  output  WIDTH  register state
- Qbar  output  WIDTH  always ~Q
- tc  output  1  terminal count, combinational
- chg  output  1  registered strobe: Q changed on the previous edge
- ovf  output  1  sticky wrap flag

## Operation
- Reset (R=1, asynchronous, overrides everything while high): Q=RESET_VAL, Qbar=~RESET_VAL, chg=0, ovf=0.
- en=0 at an edge: Q and ovf hold (clr_ovf still applies), and chg becomes 0.
- mode 00 (JK), per bit i:
  - J=0,K=0: hold
  - J=1,K=0: Q[i]=1
  - J=0,K=1: Q[i]=0
  - J=1,K=1: Q[i] toggles
- mode 01 (up): bit i toggles iff Q[i-1:0] are all 1; bit 0 always toggles. This equals Q+1 mod 2^WIDTH. Wrap from all-ones to 0 sets ovf.
- mode 10 (down): bit i toggles iff Q[i-1:0] are all 0; bit 0 always toggles. This equals Q-1 mod 2^WIDTH. Wrap from 0 to all-ones sets ovf.
- mode 11 (load): Q=J; K is ignored. Load never sets ovf.
- J and K are ignored in the count modes.
- tc:
  - 1 when mode=01 and Q is all ones
  - 1 when mode=10 and Q=0
  - 0 otherwise, independent of en
- chg: at each edge with R=0, chg is set to (next Q != current Q). It reads 1 for exactly one cycle per changing edge.
- ovf: a wrap at an edge sets ovf. Otherwise clr_ovf=1 clears it. Wrap and clr_ovf at the same edge leaves ovf=1 (set wins).
- Reset asserted mid-count aborts immediately. After R falls, the first rising edge resumes from RESET_VAL.

## Timing
- Q latency: 1 edge after inputs are sampled. Inputs must be stable before the rising edge.
- Qbar: combinational from Q, zero latency.
- tc: combinational from Q and mode, valid in the same cycle.
- chg and ovf: registered, valid in the cycle after the causing edge.
- No handshake; a new operation is accepted every enabled edge.
- R deassertion is not synchronised inside the block. The bench releases R away from the clock edge.

## Test plan
- WIDTH=4, RESET_VAL=0. Hold R=1 for 100 ns, then release → Q=0000, Qbar=1111, chg=0, ovf=0, including before any clock edge.
- JK mode from Q=0000:
  - J=0011,K=0000 → 0011
  - then J=0101,K=0101 → 0110 (bit 0 toggles to 0, bit 2 toggles to 1)
  - then J=0000,K=0000 → holds 0110, chg=0
  - then J=0000,K=0010 → 0100
  - chg=1 after each changing edge.
- Load 1110, then mode=01:
  - first edge: tc=0 before it, Q→1111, tc=1 after it
  - next edge: Q→0000, ovf=1
  - further edges: ovf stays 1
  - clr_ovf pulse → ovf=0
- Load 0001, then mode=10 for 3 edges → Q = 0000, 1111, 1110. tc=1 only while Q=0000. ovf=1 after the second edge.
- Wrap and clr_ovf=1 at the same edge → ovf=1. en=0 with mode=01 for 3 edges → Q unchanged, chg=0.
- Mid-count reset: count up to 0101, then assert R between edges → Q=0000 immediately. After release, one up edge → Q=0001, ovf=0.
